// File: rtl/mips_ctl_pkg.sv
// mips_ctl_pkg: shared ALU codes, opcode/funct values and FSM state encoding
// for the multi-cycle MIPS control unit.
package mips_ctl_pkg;
    localparam logic [3:0] ALU_AND = 4'h0;
    localparam logic [3:0] ALU_OR  = 4'h1;
    localparam logic [3:0] ALU_ADD = 4'h2;
    localparam logic [3:0] ALU_SUB = 4'h6;
    localparam logic [3:0] ALU_SLT = 4'h7;
    localparam logic [3:0] ALU_NOR = 4'hC;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [1:0] {AOP_ADD, AOP_SUB, AOP_FUNCT, AOP_IMM} aluop_t;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_RWB    = 4'd3,
        S_MEMADR = 4'd4,
        S_MEMRD  = 4'd5,
        S_MEMWB  = 4'd6,
        S_MEMWR  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IMMEX  = 4'd10,
        S_IWB    = 4'd11
    } state_t;
endpackage

// File: rtl/mips_alu_decode.sv
// mips_alu_decode: maps the FSM's ALU request plus Op/Funct to a 4-bit ALU code,
// flagging R-type funct values the ALU does not implement.
module mips_alu_decode
    import mips_ctl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  aluop_t     aluop,
    output logic [3:0] alu_code,
    output logic       illegal_funct
);
    always_comb begin
        alu_code = ALU_ADD;
        illegal_funct = 1'b0;
        case (aluop)
            AOP_SUB: alu_code = ALU_SUB;
            AOP_FUNCT:
                case (funct)
                    FN_ADD:  alu_code = ALU_ADD;
                    FN_SUB:  alu_code = ALU_SUB;
                    FN_AND:  alu_code = ALU_AND;
                    FN_OR:   alu_code = ALU_OR;
                    FN_NOR:  alu_code = ALU_NOR;
                    FN_SLT:  alu_code = ALU_SLT;
                    default: illegal_funct = 1'b1;
                endcase
            AOP_IMM:
                case (op)
                    OP_ANDI: alu_code = ALU_AND;
                    OP_ORI:  alu_code = ALU_OR;
                    OP_SLTI: alu_code = ALU_SLT;
                    default: alu_code = ALU_ADD;
                endcase
            default: alu_code = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_ctl.sv
// mips_multicycle_ctl: multi-cycle MIPS main control FSM driving datapath
// enables/selects, with memory states stretched by mem_wait.
module mips_multicycle_ctl
    import mips_ctl_pkg::*;
#(
    parameter int ALUCTL_W = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [5:0]          Op,
    input  logic [5:0]          Funct,
    input  logic                Zero,
    input  logic                mem_wait,
    output logic [ALUCTL_W-1:0] ALUctl,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSource,
    output logic                PCEn,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                illegal
);
    state_t     state, next;
    aluop_t     aluop;
    logic [3:0] alu_code;
    logic       illegal_funct, pc_write, pc_write_cond;

    always_ff @(posedge clock) state <= reset ? S_FETCH : next;

    assign aluop = state == S_EXEC   ? AOP_FUNCT :
                   state == S_IMMEX  ? AOP_IMM   :
                   state == S_BRANCH ? AOP_SUB   : AOP_ADD;

    mips_alu_decode u_alu_decode (
        .op           (Op),
        .funct        (Funct),
        .aluop        (aluop),
        .alu_code     (alu_code),
        .illegal_funct(illegal_funct)
    );

    assign ALUctl = reset ? '0 : ALUCTL_W'(alu_code);
    // pc_write_cond is only raised in BRANCH, so Zero cannot reach PCEn elsewhere
    assign PCEn = pc_write | (pc_write_cond & (Zero ^ (Op == OP_BNE)));

    always_comb begin
        next = state;
        ALUSrcA = 1'b0;
        ALUSrcB = 2'd0;
        PCSource = 2'd0;
        pc_write = 1'b0;
        pc_write_cond = 1'b0;
        IorD = 1'b0;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        IRWrite = 1'b0;
        MemtoReg = 1'b0;
        RegDst = 1'b0;
        RegWrite = 1'b0;
        illegal = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'd1;
                    IRWrite = !mem_wait;
                    pc_write = !mem_wait;
                    next = mem_wait ? S_FETCH : S_DECODE;
                end
                S_DECODE: begin
                    ALUSrcB = 2'd3;
                    case (Op)
                        OP_R:                              next = S_EXEC;
                        OP_LW, OP_SW:                      next = S_MEMADR;
                        OP_BEQ, OP_BNE:                    next = S_BRANCH;
                        OP_J:                              next = S_JUMP;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next = S_IMMEX;
                        default: begin
                            illegal = 1'b1;
                            next = S_FETCH;
                        end
                    endcase
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    illegal = illegal_funct;
                    next = illegal_funct ? S_FETCH : S_RWB;
                end
                S_RWB: begin
                    RegDst = 1'b1;
                    RegWrite = 1'b1;
                    next = S_FETCH;
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'd2;
                    next = Op == OP_LW ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD = 1'b1;
                    next = mem_wait ? S_MEMRD : S_MEMWB;
                end
                S_MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                    next = S_FETCH;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD = 1'b1;
                    next = mem_wait ? S_MEMWR : S_FETCH;
                end
                S_BRANCH: begin
                    ALUSrcA = 1'b1;
                    PCSource = 2'd1;
                    pc_write_cond = 1'b1;
                    next = S_FETCH;
                end
                S_JUMP: begin
                    PCSource = 2'd2;
                    pc_write = 1'b1;
                    next = S_FETCH;
                end
                S_IMMEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'd2;
                    next = S_IWB;
                end
                S_IWB: begin
                    RegWrite = 1'b1;
                    next = S_FETCH;
                end
                default: next = S_FETCH;
            endcase
        end
    end
endmodule
